mem_port_arbiter: RTL and testbench

//   Shares one single-ported instruction/data memory between the IF stage (fetch) and the MEM stage (load/store).

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/arb_latency_counter.sv | 29 ++
 rtl/mem_port_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM memory-port arbiter: FSM states, grant
// owner encoding and the latency-counter width helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_IF,
    GNT_MEM
  } grant_t;

  // Width needed to hold MEM_LATENCY-1 down to zero; never below one bit.
  function automatic int lat_cnt_w(input int mem_latency);
    return (mem_latency < 1) ? 1 : $clog2(mem_latency + 1);
  endfunction

endpackage

// File: rtl/arb_latency_counter.sv
// Load/decrement down-counter with a zero flag; times the wait between
// the memory strobe and the cycle its read data is valid.
module arb_latency_counter #(
  parameter int CNT_W = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_reg;

  // Load has priority; decrement stops at zero so a stray dec cannot wrap.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between the IF (fetch) and MEM
// (load/store) stages. One access at a time: IDLE -> ISSUE -> WAIT -> DONE.
// All memory-side and Ready/RData outputs are registered.
// Optional build macro FETCH_STARVE_GUARD_EN: after MAX_WAIT consecutive MEM
// grants made while IF is waiting, the next arbitration favours IF.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2,
  parameter int MAX_WAIT    = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              IFReq,
  input  logic [ADDR_W-1:0] IFAddr,
  output logic [DATA_W-1:0] IFRData,
  output logic              IFReady,
  output logic              IFStall,
  input  logic              MEMReq,
  input  logic              MEMWrite,
  input  logic [ADDR_W-1:0] MEMAddr,
  input  logic [DATA_W-1:0] MEMWData,
  output logic [DATA_W-1:0] MEMRData,
  output logic              MEMReady,
  output logic              MEMStall,
  output logic              MemEnable,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData
);

  localparam int               CNT_W    = lat_cnt_w(MEM_LATENCY);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LATENCY - 1);

  state_t            state_reg, state_next;
  grant_t            grant_reg, grant_next;
  logic              access_write_reg, access_write_next;
  logic              mem_enable_reg, mem_enable_next;
  logic              mem_write_reg, mem_write_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
  logic [DATA_W-1:0] if_rdata_reg, if_rdata_next;
  logic [DATA_W-1:0] mem_rdata_reg, mem_rdata_next;
  logic              if_ready_reg, if_ready_next;
  logic              mem_ready_reg, mem_ready_next;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic              if_favoured;
  logic              grant_if, grant_mem;

  // Arbitration only happens in IDLE; MEM wins unless the fetch guard fires.
  assign grant_mem = (state_reg == ST_IDLE) && MEMReq && !(if_favoured && IFReq);
  assign grant_if  = (state_reg == ST_IDLE) && IFReq && !grant_mem;

`ifdef FETCH_STARVE_GUARD_EN
  localparam int STARVE_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  logic [STARVE_W-1:0] starve_cnt_reg;

  // Count MEM grants taken while IF waits; any IF grant or idle IF clears it.
  always_ff @(posedge Clk) begin
    if (Reset || !IFReq || grant_if) begin
      starve_cnt_reg <= '0;
    end else if (grant_mem && (starve_cnt_reg < STARVE_W'(MAX_WAIT))) begin
      starve_cnt_reg <= starve_cnt_reg + 1'b1;
    end
  end

  assign if_favoured = (starve_cnt_reg >= STARVE_W'(MAX_WAIT));
`else
  assign if_favoured = 1'b0;
`endif

  arb_latency_counter #(
    .CNT_W(CNT_W)
  ) u_lat_cnt (
    .Clk       (Clk),
    .Reset     (Reset),
    .load      (cnt_load),
    .load_value(LAT_LOAD),
    .dec       (cnt_dec),
    .zero      (cnt_zero)
  );

  // Next-state and next-output logic; outputs are registered one cycle later.
  always_comb begin
    state_next        = state_reg;
    grant_next        = grant_reg;
    access_write_next = access_write_reg;
    mem_enable_next   = 1'b0;
    mem_write_next    = 1'b0;
    mem_addr_next     = mem_addr_reg;
    mem_wdata_next    = mem_wdata_reg;
    if_rdata_next     = if_rdata_reg;
    mem_rdata_next    = mem_rdata_reg;
    if_ready_next     = 1'b0;
    mem_ready_next    = 1'b0;
    cnt_load          = 1'b0;
    cnt_dec           = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        grant_next = GNT_NONE;
        if (grant_mem) begin
          grant_next        = GNT_MEM;
          access_write_next = MEMWrite;
          mem_addr_next     = MEMAddr;
          mem_wdata_next    = MEMWData;
          mem_enable_next   = 1'b1;
          mem_write_next    = MEMWrite;
          state_next        = ST_ISSUE;
        end else if (grant_if) begin
          grant_next        = GNT_IF;
          access_write_next = 1'b0;
          mem_addr_next     = IFAddr;
          mem_enable_next   = 1'b1;
          state_next        = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Strobe is visible this cycle; count the remaining latency.
        cnt_load   = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_zero) begin
          if (grant_reg == GNT_IF) begin
            if_rdata_next = MemRData;
            if_ready_next = 1'b1;
          end else if (grant_reg == GNT_MEM) begin
            if (!access_write_reg) begin
              mem_rdata_next = MemRData;
            end
            mem_ready_next = 1'b1;
          end
          state_next = ST_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg        <= ST_IDLE;
      grant_reg        <= GNT_NONE;
      access_write_reg <= 1'b0;
      mem_enable_reg   <= 1'b0;
      mem_write_reg    <= 1'b0;
      mem_addr_reg     <= '0;
      mem_wdata_reg    <= '0;
      if_rdata_reg     <= '0;
      mem_rdata_reg    <= '0;
      if_ready_reg     <= 1'b0;
      mem_ready_reg    <= 1'b0;
    end else begin
      state_reg        <= state_next;
      grant_reg        <= grant_next;
      access_write_reg <= access_write_next;
      mem_enable_reg   <= mem_enable_next;
      mem_write_reg    <= mem_write_next;
      mem_addr_reg     <= mem_addr_next;
      mem_wdata_reg    <= mem_wdata_next;
      if_rdata_reg     <= if_rdata_next;
      mem_rdata_reg    <= mem_rdata_next;
      if_ready_reg     <= if_ready_next;
      mem_ready_reg    <= mem_ready_next;
    end
  end

  assign MemEnable = mem_enable_reg;
  assign MemWrite  = mem_write_reg;
  assign MemAddr   = mem_addr_reg;
  assign MemWData  = mem_wdata_reg;
  assign IFRData   = if_rdata_reg;
  assign IFReady   = if_ready_reg;
  assign MEMRData  = mem_rdata_reg;
  assign MEMReady  = mem_ready_reg;
  assign IFStall   = IFReq & ~if_ready_reg;
  assign MEMStall  = MEMReq & ~mem_ready_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (MEM_LATENCY=2, MAX_WAIT=4).
// Directed scenarios plus a randomized run against a timeline model.
module tb_mem_port_arbiter;

  localparam int L  = 2;
  localparam int MW = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        IFReq, MEMReq, MEMWrite;
  logic [31:0] IFAddr, MEMAddr, MEMWData;
  logic [31:0] IFRData, MEMRData, MemAddr, MemWData, MemRData;
  logic        IFReady, IFStall, MEMReady, MEMStall, MemEnable, MemWrite;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_if_rdata, exp_mem_rdata;
  logic [31:0] ref_mem [256];

  always #5 Clk = ~Clk;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L), .MAX_WAIT(MW)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .IFReq(IFReq), .IFAddr(IFAddr), .IFRData(IFRData), .IFReady(IFReady), .IFStall(IFStall),
    .MEMReq(MEMReq), .MEMWrite(MEMWrite), .MEMAddr(MEMAddr), .MEMWData(MEMWData),
    .MEMRData(MEMRData), .MEMReady(MEMReady), .MEMStall(MEMStall),
    .MemEnable(MemEnable), .MemWrite(MemWrite), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 1) ? 32'h8C22_0000 : (32'h1000_0000 + 32'(i) * 32'h0001_0003);
  endfunction

  // Memory device: data valid two cycles after the strobe cycle, noise otherwise.
  logic [31:0] mem [256];
  bit          mem_written [256];
  logic        pipe_v = 1'b0;
  logic [31:0] pipe_d;
  always @(posedge Clk) begin
    if (MemEnable === 1'b1 && MemWrite === 1'b1) begin
      mem[MemAddr[9:2]]         <= MemWData;
      mem_written[MemAddr[9:2]] <= 1'b1;
    end
    pipe_v   <= (MemEnable === 1'b1) && (MemWrite !== 1'b1);
    pipe_d   <= mem_written[MemAddr[9:2]] ? mem[MemAddr[9:2]] : init_word(int'(MemAddr[9:2]));
    MemRData <= pipe_v ? pipe_d : $urandom;
  end

  task automatic clear_inputs();
    IFReq = 0; IFAddr = 0; MEMReq = 0; MEMWrite = 0; MEMAddr = 0; MEMWData = 0;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    clear_inputs();
    Reset = 1;
    repeat (2) @(negedge Clk);
    #1;
    checks++; if (MemEnable !== 1'b0) begin errors++; $display("FAIL rst_mem_enable got=%b exp=0", MemEnable); end
    checks++; if (MemWrite !== 1'b0) begin errors++; $display("FAIL rst_mem_write got=%b exp=0", MemWrite); end
    checks++; if (IFReady !== 1'b0 || MEMReady !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b%b exp=00", IFReady, MEMReady); end
    checks++; if (MemAddr !== 32'h0 || MemWData !== 32'h0) begin errors++; $display("FAIL rst_mem_port got=%h/%h exp=0/0", MemAddr, MemWData); end
    checks++; if (IFRData !== 32'h0 || MEMRData !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h/%h exp=0/0", IFRData, MEMRData); end
    Reset = 0;
    exp_if_rdata = 0; exp_mem_rdata = 0;
  endtask

  task automatic test_if_fetch();
    for (int k = 0; k < 8; k++) begin
      @(negedge Clk);
      if (k == 0) begin IFReq = 1; IFAddr = 32'h4; end
      #1;
      checks++; if (MemEnable !== (k == 1)) begin errors++; $display("FAIL t1_mem_enable cyc=%0d got=%b exp=%b", k, MemEnable, k == 1); end
      checks++; if (IFReady !== (k == 4)) begin errors++; $display("FAIL t1_if_ready cyc=%0d got=%b exp=%b", k, IFReady, k == 4); end
      checks++; if (MEMReady !== 1'b0) begin errors++; $display("FAIL t1_mem_ready cyc=%0d got=%b exp=0", k, MEMReady); end
      checks++; if (IFStall !== (k < 4)) begin errors++; $display("FAIL t1_if_stall cyc=%0d got=%b exp=%b", k, IFStall, k < 4); end
      if (k == 1) begin checks++; if (MemAddr !== 32'h4) begin errors++; $display("FAIL t1_mem_addr got=%h exp=00000004", MemAddr); end end
      if (k == 4) begin
        exp_if_rdata = 32'h8C22_0000;
        checks++; if (IFRData !== exp_if_rdata) begin errors++; $display("FAIL t1_if_rdata got=%h exp=%h", IFRData, exp_if_rdata); end
        IFReq = 0;
      end
    end
  endtask

  task automatic test_arbitration();
    for (int k = 0; k < 12; k++) begin
      @(negedge Clk);
      if (k == 0) begin IFReq = 1; IFAddr = 32'h8; MEMReq = 1; MEMWrite = 0; MEMAddr = 32'h100; end
      #1;
      checks++; if (MemEnable !== (k == 1 || k == 6)) begin errors++; $display("FAIL t2_mem_enable cyc=%0d got=%b exp=%b", k, MemEnable, k == 1 || k == 6); end
      checks++; if (MEMReady !== (k == 4)) begin errors++; $display("FAIL t2_mem_ready cyc=%0d got=%b exp=%b", k, MEMReady, k == 4); end
      checks++; if (IFReady !== (k == 9)) begin errors++; $display("FAIL t2_if_ready cyc=%0d got=%b exp=%b", k, IFReady, k == 9); end
      checks++; if (IFStall !== (k <= 8)) begin errors++; $display("FAIL t2_if_stall cyc=%0d got=%b exp=%b", k, IFStall, k <= 8); end
      checks++; if (MEMStall !== (k <= 3)) begin errors++; $display("FAIL t2_mem_stall cyc=%0d got=%b exp=%b", k, MEMStall, k <= 3); end
      if (k == 4) begin
        exp_mem_rdata = init_word(64);
        checks++; if (MEMRData !== exp_mem_rdata) begin errors++; $display("FAIL t2_mem_rdata got=%h exp=%h", MEMRData, exp_mem_rdata); end
        MEMReq = 0;
      end
      if (k == 9) begin
        exp_if_rdata = init_word(2);
        checks++; if (IFRData !== exp_if_rdata) begin errors++; $display("FAIL t2_if_rdata got=%h exp=%h", IFRData, exp_if_rdata); end
        IFReq = 0;
      end
    end
  endtask

  task automatic test_store();
    for (int k = 0; k < 8; k++) begin
      @(negedge Clk);
      if (k == 0) begin MEMReq = 1; MEMWrite = 1; MEMAddr = 32'h40; MEMWData = 32'hDEAD_BEEF; end
      #1;
      checks++; if (MemEnable !== (k == 1)) begin errors++; $display("FAIL t3_mem_enable cyc=%0d got=%b exp=%b", k, MemEnable, k == 1); end
      checks++; if (MEMReady !== (k == 4)) begin errors++; $display("FAIL t3_mem_ready cyc=%0d got=%b exp=%b", k, MEMReady, k == 4); end
      if (k == 1) begin
        checks++; if (MemWrite !== 1'b1 || MemWData !== 32'hDEAD_BEEF || MemAddr !== 32'h40) begin
          errors++; $display("FAIL t3_write_port got=%b/%h/%h exp=1/deadbeef/00000040", MemWrite, MemWData, MemAddr);
        end
      end
      checks++; if (MEMRData !== exp_mem_rdata) begin errors++; $display("FAIL t3_mem_rdata_hold cyc=%0d got=%h exp=%h", k, MEMRData, exp_mem_rdata); end
      if (k == 4) MEMReq = 0;
    end
    ref_mem[16] = 32'hDEAD_BEEF;
    checks++; if (mem[16] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL t3_mem_content got=%h exp=deadbeef", mem[16]); end
  endtask

  task automatic test_reset_mid_access();
    for (int k = 0; k < 10; k++) begin
      @(negedge Clk);
      if (k == 0) begin IFReq = 1; IFAddr = 32'hC; end
      if (k == 2) Reset = 1;
      if (k == 3) Reset = 0;
      #1;
      if (k == 1 || k >= 3) begin
        checks++; if (MemEnable !== (k == 1 || k == 4)) begin errors++; $display("FAIL t4_mem_enable cyc=%0d got=%b exp=%b", k, MemEnable, k == 1 || k == 4); end
      end
      if (k >= 3) begin
        checks++; if (IFReady !== (k == 7)) begin errors++; $display("FAIL t4_if_ready cyc=%0d got=%b exp=%b", k, IFReady, k == 7); end
      end
      if (k == 3) begin checks++; if (IFRData !== 32'h0) begin errors++; $display("FAIL t4_if_rdata_rst got=%h exp=0", IFRData); end end
      if (k == 7) begin
        exp_if_rdata = init_word(3);
        checks++; if (IFRData !== exp_if_rdata) begin errors++; $display("FAIL t4_if_rdata got=%h exp=%h", IFRData, exp_if_rdata); end
        IFReq = 0;
      end
    end
  endtask

  task automatic test_req_drop();
    for (int k = 0; k < 10; k++) begin
      @(negedge Clk);
      if (k == 0) begin IFReq = 1; IFAddr = 32'h4; end
      if (k == 2) IFReq = 0;
      #1;
      checks++; if (MemEnable !== (k == 1)) begin errors++; $display("FAIL t6_mem_enable cyc=%0d got=%b exp=%b", k, MemEnable, k == 1); end
      checks++; if (IFReady !== (k == 4)) begin errors++; $display("FAIL t6_if_ready cyc=%0d got=%b exp=%b", k, IFReady, k == 4); end
      if (k == 4) begin checks++; if (IFRData !== 32'h8C22_0000) begin errors++; $display("FAIL t6_if_rdata got=%h exp=8c220000", IFRData); end end
    end
  endtask

  task automatic test_starve();
    int seq [$];
    int n_if;
    n_if = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (k == 0) begin IFReq = 1; IFAddr = 32'h4; MEMReq = 1; MEMWrite = 0; MEMAddr = 32'h200; end
      #1;
      if (MemEnable === 1'b1) begin
        seq.push_back((MemAddr == 32'h4) ? 1 : 2);
        if (MemAddr == 32'h4) n_if++;
      end
    end
    @(negedge Clk);
    clear_inputs();
    repeat (8) @(negedge Clk);
    checks++; if (seq.size() < 7) begin errors++; $display("FAIL t5_grant_count got=%0d exp>=7", seq.size()); end
`ifdef FETCH_STARVE_GUARD_EN
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= seq.size()) begin errors++; $display("FAIL t5_grant_seq idx=%0d got=none exp=%0d", i, (i == 4) ? 1 : 2); end
      else if (seq[i] != ((i == 4) ? 1 : 2)) begin errors++; $display("FAIL t5_grant_seq idx=%0d got=%0d exp=%0d", i, seq[i], (i == 4) ? 1 : 2); end
    end
`else
    checks++; if (n_if != 0) begin errors++; $display("FAIL t5_if_grants got=%0d exp=0", n_if); end
`endif
  endtask

  task automatic test_random();
    int idle_from, issue_at, done_at, cur, starve, idx;
    bit pick_if, exp_wr, exp_ifr, exp_memr;
    logic [31:0] exp_addr, exp_wdata, exp_data;
    @(negedge Clk);
    clear_inputs();
    Reset = 1;
    repeat (2) @(negedge Clk);
    Reset = 0;
    exp_if_rdata = 0; exp_mem_rdata = 0;
    idle_from = 0; issue_at = -1; done_at = -1; cur = 0; starve = 0;
    exp_wr = 0; exp_addr = 0; exp_wdata = 0; exp_data = 0;
    for (int k = 0; k < 600; k++) begin
      if (k > 0) @(negedge Clk);
      if (!IFReq && $urandom_range(2) == 0) begin IFReq = 1; IFAddr = 32'($urandom_range(255)) << 2; end
      if (!MEMReq && $urandom_range(2) == 0) begin
        MEMReq = 1; MEMWrite = 1'($urandom_range(1)); MEMAddr = 32'($urandom_range(255)) << 2; MEMWData = $urandom;
      end
      #1;
      // Model: one access per L+3 cycles, MEM first unless the guard says IF.
      if (k >= idle_from && (IFReq || MEMReq)) begin
        pick_if = !MEMReq;
`ifdef FETCH_STARVE_GUARD_EN
        if (IFReq && starve >= MW) pick_if = 1;
        if (pick_if) starve = 0; else if (IFReq) starve++;
`endif
        cur = pick_if ? 1 : 2;
        issue_at = k + 1; done_at = k + L + 2; idle_from = k + L + 3;
        exp_addr = pick_if ? IFAddr : MEMAddr;
        exp_wr = !pick_if && MEMWrite;
        exp_wdata = MEMWData;
        idx = int'(exp_addr[9:2]);
        if (exp_wr) ref_mem[idx] = MEMWData; else exp_data = ref_mem[idx];
      end
`ifdef FETCH_STARVE_GUARD_EN
      if (!IFReq) starve = 0;
`endif
      exp_ifr  = (k == done_at) && (cur == 1);
      exp_memr = (k == done_at) && (cur == 2);
      if (exp_ifr) exp_if_rdata = exp_data;
      if (exp_memr && !exp_wr) exp_mem_rdata = exp_data;
      checks++; if (MemEnable !== (k == issue_at)) begin errors++; $display("FAIL rnd_mem_enable cyc=%0d got=%b exp=%b", k, MemEnable, k == issue_at); end
      if (k == issue_at) begin
        checks++; if (MemAddr !== exp_addr || MemWrite !== exp_wr) begin
          errors++; $display("FAIL rnd_issue cyc=%0d got=%h/%b exp=%h/%b", k, MemAddr, MemWrite, exp_addr, exp_wr);
        end
        if (exp_wr) begin checks++; if (MemWData !== exp_wdata) begin errors++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", k, MemWData, exp_wdata); end end
      end
      checks++; if (IFReady !== exp_ifr) begin errors++; $display("FAIL rnd_if_ready cyc=%0d got=%b exp=%b", k, IFReady, exp_ifr); end
      checks++; if (MEMReady !== exp_memr) begin errors++; $display("FAIL rnd_mem_ready cyc=%0d got=%b exp=%b", k, MEMReady, exp_memr); end
      checks++; if (IFRData !== exp_if_rdata) begin errors++; $display("FAIL rnd_if_rdata cyc=%0d got=%h exp=%h", k, IFRData, exp_if_rdata); end
      checks++; if (MEMRData !== exp_mem_rdata) begin errors++; $display("FAIL rnd_mem_rdata cyc=%0d got=%h exp=%h", k, MEMRData, exp_mem_rdata); end
      checks++; if (IFStall !== (IFReq && !exp_ifr) || MEMStall !== (MEMReq && !exp_memr)) begin
        errors++; $display("FAIL rnd_stall cyc=%0d got=%b%b exp=%b%b", k, IFStall, MEMStall, IFReq && !exp_ifr, MEMReq && !exp_memr);
      end
      if (exp_ifr) IFReq = 0;
      if (exp_memr) MEMReq = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    clear_inputs();
    Reset = 1;
    test_reset();
    test_if_fetch();
    test_arbitration();
    test_store();
    test_reset_mid_access();
    test_req_drop();
    test_starve();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
